// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the RV32I
// instruction-fetch requester and the load/store requester. One transaction
// is outstanding at a time; data accesses have priority, but fetch is granted
// after STARVE_LIMIT consecutive data grants while it waits. A flushed fetch
// response is swallowed instead of being returned.
// Optional feature macro: ARB_PERF_CNT_EN enables the saturating wait-cycle
// counters; without it both counter outputs are tied to zero.
module mem_port_arbiter #(
    parameter int XLEN               = 32,
    parameter int STARVE_LIMIT       = 4,
    parameter int PERF_COUNTER_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    // fetch requester
    input  logic                          i_req,
    input  logic [XLEN-1:0]               i_addr,
    input  logic                          i_flush,
    output logic                          i_gnt,
    output logic                          i_rvalid,
    output logic [XLEN-1:0]               i_rdata,
    // load/store requester
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [XLEN-1:0]               d_addr,
    input  logic [XLEN-1:0]               d_wdata,
    input  logic [3:0]                    d_be,
    output logic                          d_gnt,
    output logic                          d_rvalid,
    output logic [XLEN-1:0]               d_rdata,
    // downstream memory
    output logic                          mem_req,
    output logic                          mem_we,
    output logic [XLEN-1:0]               mem_addr,
    output logic [XLEN-1:0]               mem_wdata,
    output logic [3:0]                    mem_be,
    input  logic                          mem_ready,
    input  logic                          mem_rvalid,
    input  logic [XLEN-1:0]               mem_rdata,
    // performance counters
    output logic [PERF_COUNTER_WIDTH-1:0] i_wait_cnt,
    output logic [PERF_COUNTER_WIDTH-1:0] d_wait_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);

    state_t          state_q;
    state_t          state_d;
    logic [3:0]      streak_q;
    logic [3:0]      streak_d;
    logic            drop_q;
    logic            drop_d;
    logic [XLEN-1:0] i_rdata_q;
    logic [XLEN-1:0] d_rdata_q;

    logic            i_wins;
    logic            d_wins;
    logic            i_resp;
    logic            d_resp;

    // Streak counter increment that never exceeds the starvation limit.
    function automatic logic [3:0] streak_inc(input logic [3:0] val);
        if (val >= STREAK_MAX) begin
            return STREAK_MAX;
        end
        return val + 4'd1;
    endfunction

    // Data wins unless fetch has been passed over STARVE_LIMIT times in a row.
    always_comb begin
        i_wins = i_req && (!d_req || (streak_q == STREAK_MAX));
        d_wins = d_req && !i_wins;
    end

    // Next-state logic, downstream command mux, grants and response steering.
    always_comb begin
        state_d   = state_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = 4'b0000;
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        i_resp    = 1'b0;
        d_resp    = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_wins) begin
                    // Fetch always reads a full word.
                    mem_req  = 1'b1;
                    mem_addr = i_addr;
                    mem_be   = 4'b1111;
                    if (mem_ready) begin
                        i_gnt   = 1'b1;
                        state_d = BUSY_I;
                    end
                end else if (d_wins) begin
                    mem_req   = 1'b1;
                    mem_we    = d_we;
                    mem_addr  = d_addr;
                    mem_wdata = d_wdata;
                    mem_be    = d_be;
                    if (mem_ready) begin
                        d_gnt   = 1'b1;
                        state_d = BUSY_D;
                    end
                end
            end
            BUSY_I: begin
                if (mem_rvalid) begin
                    i_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_rvalid) begin
                    d_resp  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Starvation streak: only arbitration (IDLE) cycles move it.
    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (!i_req || i_gnt) begin
                streak_d = 4'd0;
            end else if (d_gnt) begin
                streak_d = streak_inc(streak_q);
            end
        end
    end

    // Drop flag: a flush during the fetch (or at its grant) kills its response.
    always_comb begin
        drop_d = drop_q;
        if (i_resp) begin
            drop_d = 1'b0;
        end else if (i_flush && ((state_q == BUSY_I) || i_gnt)) begin
            drop_d = 1'b1;
        end
    end

    // Responses pass straight through; a flush arriving with the response
    // itself also suppresses it.
    always_comb begin
        i_rvalid = i_resp && !drop_q && !i_flush;
        d_rvalid = d_resp;
        i_rdata  = i_rvalid ? mem_rdata : i_rdata_q;
        d_rdata  = d_rvalid ? mem_rdata : d_rdata_q;
    end

    // Control state and the held read-data copies.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            streak_q  <= 4'd0;
            drop_q    <= 1'b0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            drop_q   <= drop_d;
            if (i_rvalid) begin
                i_rdata_q <= mem_rdata;
            end
            if (d_rvalid) begin
                d_rdata_q <= mem_rdata;
            end
        end
    end

`ifdef ARB_PERF_CNT_EN
    logic [PERF_COUNTER_WIDTH-1:0] i_wait_q;
    logic [PERF_COUNTER_WIDTH-1:0] d_wait_q;

    // Saturating increment for the wait counters.
    function automatic logic [PERF_COUNTER_WIDTH-1:0] sat_inc(
        input logic [PERF_COUNTER_WIDTH-1:0] val
    );
        if (&val) begin
            return val;
        end
        return val + 1'b1;
    endfunction

    // Count every cycle a requester is asking but not being granted.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_wait_q <= '0;
            d_wait_q <= '0;
        end else begin
            if (i_req && !i_gnt) begin
                i_wait_q <= sat_inc(i_wait_q);
            end
            if (d_req && !d_gnt) begin
                d_wait_q <= sat_inc(d_wait_q);
            end
        end
    end

    assign i_wait_cnt = i_wait_q;
    assign d_wait_cnt = d_wait_q;
`else
    assign i_wait_cnt = '0;
    assign d_wait_cnt = '0;
`endif

`ifndef SYNTHESIS
    // A response with nothing outstanding is a downstream protocol error.
    a_no_idle_rvalid: assert property (@(posedge clk) disable iff (rst)
        !((state_q == IDLE) && mem_rvalid));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed stimulus pushes expected
// grants and responses into queues; a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int XLEN = 32;
    localparam int PCW  = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_req, i_flush, i_gnt, i_rvalid;
    logic [XLEN-1:0] i_addr, i_rdata;
    logic            d_req, d_we, d_gnt, d_rvalid;
    logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
    logic [3:0]      d_be;
    logic            mem_req, mem_we, mem_ready, mem_rvalid;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]      mem_be;
    logic [PCW-1:0]  i_wait_cnt, d_wait_cnt;

    typedef struct {
        logic        is_i;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gnt_t;

    typedef struct {
        logic        is_i;
        logic [31:0] data;
    } resp_t;

    gnt_t  gq[$];
    resp_t rq[$];
    gnt_t  mon_g;
    resp_t mon_r;

    int checks = 0;
    int errors = 0;
    int lat    = 1;

    logic [31:0] mem_model [logic [31:0]];

    mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4), .PERF_COUNTER_WIDTH(PCW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic is_i, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] be);
        gnt_t g;
        g.is_i = is_i; g.we = we; g.addr = addr; g.wdata = wdata; g.be = be;
        gq.push_back(g);
    endtask

    task automatic push_resp(input logic is_i, input logic [31:0] data);
        resp_t r;
        r.is_i = is_i; r.data = data;
        rq.push_back(r);
    endtask

    // Wait (bounded) until every expected event has been seen.
    task automatic drain(input string name);
        for (int k = 0; k < 40 && (gq.size() != 0 || rq.size() != 0); k++) begin
            @(posedge clk);
        end
        #1;
        chk(name, 64'(gq.size() + rq.size()), 64'd0);
    endtask

    // Issue one data access and hold it until granted.
    task automatic do_data(input string name, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be,
                           input logic [31:0] exp_rdata);
        bit got = 0;
        push_gnt(1'b0, we, addr, wdata, be);
        push_resp(1'b0, exp_rdata);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (d_gnt) got = 1;
        end
        chk({name, "_gnt_seen"}, 64'(got), 64'd1);
        tick();
        d_req = 1'b0;
        drain({name, "_drain"});
    endtask

    // Issue one fetch and hold it until granted.
    task automatic do_fetch(input string name, input logic [31:0] addr,
                            input logic [31:0] exp_rdata);
        bit got = 0;
        push_gnt(1'b1, 1'b0, addr, 32'h0, 4'b1111);
        push_resp(1'b1, exp_rdata);
        i_req = 1'b1; i_addr = addr;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (i_gnt) got = 1;
        end
        chk({name, "_gnt_seen"}, 64'(got), 64'd1);
        tick();
        i_req = 1'b0;
        drain({name, "_drain"});
    endtask

    // Downstream memory model: answers each accepted command after lat cycles.
    initial begin : mem_model_proc
        int          cnt;
        logic [31:0] resp;
        logic [31:0] w;
        cnt = 0;
        resp = '0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_rvalid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = resp;
                end
            end
            @(negedge clk);
            if (rst) begin
                cnt = 0;
            end else if (mem_req && mem_ready) begin
                cnt = lat;
                if (mem_we) begin
                    w = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                    for (int b = 0; b < 4; b++) begin
                        if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
                    end
                    mem_model[mem_addr] = w;
                    resp = 32'h0;
                end else begin
                    resp = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'h0;
                end
            end
        end
    end

    // Monitor: every grant and every response must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_gnt || d_gnt) begin
                if (gq.size() == 0) begin
                    chk("unexpected_gnt", 64'({i_gnt, d_gnt}), 64'd0);
                end else begin
                    mon_g = gq.pop_front();
                    chk("gnt_owner", 64'({i_gnt, d_gnt}), mon_g.is_i ? 64'd2 : 64'd1);
                    chk("gnt_mem_req", 64'(mem_req), 64'd1);
                    chk("gnt_mem_we", 64'(mem_we), 64'(mon_g.we));
                    chk("gnt_mem_addr", 64'(mem_addr), 64'(mon_g.addr));
                    if (mon_g.we) begin
                        chk("gnt_mem_wdata", 64'(mem_wdata), 64'(mon_g.wdata));
                        chk("gnt_mem_be", 64'(mem_be), 64'(mon_g.be));
                    end
                end
            end
            if (i_rvalid || d_rvalid) begin
                if (rq.size() == 0) begin
                    chk("unexpected_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
                end else begin
                    mon_r = rq.pop_front();
                    chk("resp_owner", 64'({i_rvalid, d_rvalid}), mon_r.is_i ? 64'd2 : 64'd1);
                    chk("resp_data", mon_r.is_i ? 64'(i_rdata) : 64'(d_rdata), 64'(mon_r.data));
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] exp_cnt;
`ifdef ARB_PERF_CNT_EN
        exp_cnt = 32'd3;
`else
        exp_cnt = 32'd0;
`endif
        rst = 1'b1;
        i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        mem_ready = 1'b1;
        mem_model[32'h80]  = 32'h0BADF00D;
        mem_model[32'h100] = 32'h00000013;
        mem_model[32'h200] = 32'hAAAA0001;
        mem_model[32'h300] = 32'h55AA55AA;
        mem_model[32'h500] = 32'h12345678;
        mem_model[32'h504] = 32'h00A00093;
        mem_model[32'h508] = 32'hFFFFFFFF;
        tick();
        tick();
        @(negedge clk);
        chk("rst_gnt", 64'({i_gnt, d_gnt}), 64'd0);
        chk("rst_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        chk("rst_i_rdata", 64'(i_rdata), 64'd0);
        chk("rst_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_cnts", {i_wait_cnt, d_wait_cnt}, 64'd0);
        tick();
        rst = 1'b0;

        // Backpressure: three cycles of mem_ready=0, command held stable.
        lat = 1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'b1111;
        mem_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_no_gnt", 64'(d_gnt), 64'd0);
            chk("bp_mem_req", 64'(mem_req), 64'd1);
            chk("bp_mem_addr", 64'(mem_addr), 64'h80);
            chk("bp_mem_we", 64'(mem_we), 64'd0);
            tick();
        end
        mem_ready = 1'b1;
        push_gnt(1'b0, 1'b0, 32'h80, 32'h0, 4'b1111);
        push_resp(1'b0, 32'h0BADF00D);
        @(negedge clk);
        chk("bp_d_wait_cnt", 64'(d_wait_cnt), 64'(exp_cnt));
        chk("bp_i_wait_cnt", 64'(i_wait_cnt), 64'd0);
        tick();
        d_req = 1'b0;
        drain("bp_drain");

        // Lone fetch with a 2-cycle memory.
        lat = 2;
        push_gnt(1'b1, 1'b0, 32'h100, 32'h0, 4'b1111);
        push_resp(1'b1, 32'h00000013);
        i_req = 1'b1; i_addr = 32'h100;
        @(negedge clk);
        chk("lone_gnt_c0", 64'({i_gnt, d_gnt}), 64'd2);
        tick();
        i_req = 1'b0;
        @(negedge clk);
        chk("lone_rvalid_c1", 64'(i_rvalid), 64'd0);
        tick();
        @(negedge clk);
        chk("lone_rvalid_c2", 64'({i_rvalid, d_rvalid}), 64'd2);
        chk("lone_rdata_c2", 64'(i_rdata), 64'h13);
        drain("lone_drain");

        // Contention with a 1-cycle memory: D,D,D,D,I,D,D,D,D,I.
        lat = 1;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 4; k++) begin
                push_gnt(1'b0, 1'b0, 32'h300, 32'h0, 4'b0000);
                push_resp(1'b0, 32'h55AA55AA);
            end
            push_gnt(1'b1, 1'b0, 32'h200, 32'h0, 4'b1111);
            push_resp(1'b1, 32'hAAAA0001);
        end
        i_req = 1'b1; i_addr = 32'h200;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; d_be = 4'b0000;
        repeat (20) tick();
        i_req = 1'b0; d_req = 1'b0;
        drain("cont_drain");

        // Store then load of the same word.
        do_data("store", 1'b1, 32'h40, 32'hDEADBEEF, 4'b1111, 32'h0);
        do_data("load", 1'b0, 32'h40, 32'h0, 4'b1111, 32'hDEADBEEF);
        tick();
        @(negedge clk);
        chk("d_rdata_hold", 64'(d_rdata), 64'hDEADBEEF);
        chk("d_rvalid_idle", 64'(d_rvalid), 64'd0);
        tick();

        // Flush while the fetch is outstanding.
        lat = 2;
        push_gnt(1'b1, 1'b0, 32'h500, 32'h0, 4'b1111);
        i_req = 1'b1; i_addr = 32'h500;
        @(negedge clk);
        chk("flush_gnt", 64'(i_gnt), 64'd1);
        tick();
        i_req = 1'b0; i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        @(negedge clk);
        chk("flush_no_rvalid", 64'(i_rvalid), 64'd0);
        chk("flush_rdata_hold", 64'(i_rdata), 64'hAAAA0001);
        repeat (2) tick();
        drain("flush_drain");

        // Flush in the same cycle as the grant.
        push_gnt(1'b1, 1'b0, 32'h508, 32'h0, 4'b1111);
        i_req = 1'b1; i_addr = 32'h508; i_flush = 1'b1;
        tick();
        i_req = 1'b0; i_flush = 1'b0;
        repeat (4) tick();
        drain("flush_gnt_drain");

        // Flush in IDLE with no request is a no-op; next fetch returns.
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        do_fetch("refetch", 32'h504, 32'h00A00093);

        // Reset while a store is outstanding.
        lat = 3;
        push_gnt(1'b0, 1'b1, 32'h44, 32'h11112222, 4'b0011);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'h11112222; d_be = 4'b0011;
        @(negedge clk);
        chk("rst_mid_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0; d_we = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_gnt_out", 64'({i_gnt, d_gnt}), 64'd0);
        chk("rst_mid_rvalid", 64'({i_rvalid, d_rvalid}), 64'd0);
        chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mid_i_rdata", 64'(i_rdata), 64'd0);
        chk("rst_mid_d_rdata", 64'(d_rdata), 64'd0);
        chk("rst_mid_cnts", {i_wait_cnt, d_wait_cnt}, 64'd0);
        tick();
        lat = 1;
        push_gnt(1'b0, 1'b0, 32'h40, 32'h0, 4'b1111);
        push_resp(1'b0, 32'hDEADBEEF);
        d_req = 1'b1; d_addr = 32'h40; d_be = 4'b1111;
        @(negedge clk);
        chk("rst_mid_idle_gnt", 64'(d_gnt), 64'd1);
        tick();
        d_req = 1'b0;
        repeat (4) tick();
        drain("final_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
